// File: rtl/iir_mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// iir_mac_sequencer_pkg
// Shared definitions for the sequential IIR multiply-accumulate block:
// datapath widths, tap counts, power-up coefficient values and the FSM
// state type. No ports; import with iir_mac_sequencer_pkg::*.
// ---------------------------------------------------------------------------
package iir_mac_sequencer_pkg;

    localparam int DATA_WIDTH  = 20;
    localparam int COEFF_WIDTH = 8;
    localparam int ACC_WIDTH   = 24;

    localparam int NUM_X_TAPS  = 4;
    localparam int NUM_Y_TAPS  = 3;
    localparam int NUM_TAPS    = NUM_X_TAPS + NUM_Y_TAPS;

    // Power-up coefficients: taps 0..3 feed-forward, taps 4..6 feedback.
    localparam logic [COEFF_WIDTH-1:0] C0 = 8'h06;
    localparam logic [COEFF_WIDTH-1:0] C1 = 8'h12;
    localparam logic [COEFF_WIDTH-1:0] C2 = 8'h25;
    localparam logic [COEFF_WIDTH-1:0] C3 = 8'h06;
    localparam logic [COEFF_WIDTH-1:0] C4 = 8'h81;
    localparam logic [COEFF_WIDTH-1:0] C5 = 8'h5B;
    localparam logic [COEFF_WIDTH-1:0] C6 = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iir_mac_sequencer_mult_tc.sv
// ---------------------------------------------------------------------------
// mult_tc
// Combinational signed two's-complement multiplier shared by every tap.
// Ports:
//   a, b : signed WIDTH-bit operands
//   p    : signed 2*WIDTH-bit product
// ---------------------------------------------------------------------------
module mult_tc #(
    parameter int WIDTH = iir_mac_sequencer_pkg::COEFF_WIDTH
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    // Both operands are signed, so they are sign-extended to the product
    // width before multiplying.
    assign p = a * b;

endmodule

// File: rtl/iir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// iir_mac_sequencer
// Seven-tap IIR filter evaluated one tap per clock on a single multiplier.
// Each synchronized rising edge of lrck accepts one sample, runs taps 0..6
// (x1..x4 feed-forward, y1..y3 feedback) and presents a saturated result.
// Ports:
//   clock, reset      : system clock (rising edge), async active-low reset
//   lrck              : sample strobe, asynchronous to clock
//   x_in              : signed input sample, captured at start
//   cfg_we/addr/data  : shadow coefficient write (addr 7 ignored)
//   clr_ovr           : clears the sticky overrun flag
//   y_out, y_valid    : filtered sample and its one-cycle strobe
//   busy              : a sample is being processed
//   ovr               : a sample strobe arrived while busy and was dropped
// ---------------------------------------------------------------------------
module iir_mac_sequencer #(
    parameter int DATA_WIDTH  = iir_mac_sequencer_pkg::DATA_WIDTH,
    parameter int COEFF_WIDTH = iir_mac_sequencer_pkg::COEFF_WIDTH,
    parameter int ACC_WIDTH   = iir_mac_sequencer_pkg::ACC_WIDTH,
    parameter logic [COEFF_WIDTH-1:0] C0 = iir_mac_sequencer_pkg::C0,
    parameter logic [COEFF_WIDTH-1:0] C1 = iir_mac_sequencer_pkg::C1,
    parameter logic [COEFF_WIDTH-1:0] C2 = iir_mac_sequencer_pkg::C2,
    parameter logic [COEFF_WIDTH-1:0] C3 = iir_mac_sequencer_pkg::C3,
    parameter logic [COEFF_WIDTH-1:0] C4 = iir_mac_sequencer_pkg::C4,
    parameter logic [COEFF_WIDTH-1:0] C5 = iir_mac_sequencer_pkg::C5,
    parameter logic [COEFF_WIDTH-1:0] C6 = iir_mac_sequencer_pkg::C6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   lrck,
    input  logic [DATA_WIDTH-1:0]  x_in,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [COEFF_WIDTH-1:0] cfg_data,
    input  logic                   clr_ovr,
    output logic [DATA_WIDTH-1:0]  y_out,
    output logic                   y_valid,
    output logic                   busy,
    output logic                   ovr
);

    import iir_mac_sequencer_pkg::*;

    localparam int PROD_WIDTH = 2 * COEFF_WIDTH;
    localparam int TERM_SHIFT = 4;
    localparam int TERM_EXT   = ACC_WIDTH - PROD_WIDTH - TERM_SHIFT;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));

    localparam logic [COEFF_WIDTH-1:0] DEFAULT_BANK [7] =
        '{C0, C1, C2, C3, C4, C5, C6};

    // Clamp the accumulator into the signed output range.
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    // [0],[1]: two-flop synchronizer; [2]: previous value for edge detect.
    logic [2:0]                    lrck_sync;
    logic                          start;

    state_t                        state;
    state_t                        state_next;

    logic [DATA_WIDTH-1:0]         x_hist [4];
    logic [DATA_WIDTH-1:0]         y_hist [3];
    logic [COEFF_WIDTH-1:0]        shadow [7];
    logic [COEFF_WIDTH-1:0]        active [7];
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [2:0]                    tap;

    logic signed [COEFF_WIDTH-1:0] operand;
    logic signed [COEFF_WIDTH-1:0] coeff;
    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]   term;

    // ---------------- lrck synchronizer and start detect ----------------
    // NOTE: clocked state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its neighbours (the shift chain relies on it).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            lrck_sync <= '0;
        else
            lrck_sync <= {lrck_sync[1:0], lrck};
    end

    assign start = lrck_sync[1] & ~lrck_sync[2];

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every combinational output is given a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_MAC;
            ST_MAC:  if (tap == 3'd6) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // ---------------- tap operand selection ----------------
    // The multiplier sees only the top COEFF_WIDTH bits of each history word.
    always_comb begin
        operand = '0;
        coeff   = '0;
        case (tap)
            3'd0: begin operand = x_hist[0][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[0]; end
            3'd1: begin operand = x_hist[1][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[1]; end
            3'd2: begin operand = x_hist[2][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[2]; end
            3'd3: begin operand = x_hist[3][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[3]; end
            3'd4: begin operand = y_hist[0][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[4]; end
            3'd5: begin operand = y_hist[1][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[5]; end
            3'd6: begin operand = y_hist[2][DATA_WIDTH-1 -: COEFF_WIDTH]; coeff = active[6]; end
            default: ;
        endcase
    end

    mult_tc #(
        .WIDTH (COEFF_WIDTH)
    ) u_mult (
        .a (operand),
        .b (coeff),
        .p (product)
    );

    // Product is sign-extended and scaled by 16 to line up with the
    // sample's fractional position inside the accumulator.
    assign term = {{TERM_EXT{product[PROD_WIDTH-1]}}, product, {TERM_SHIFT{1'b0}}};

    // ---------------- shadow coefficient bank ----------------
    // NOTE: the coefficient banks are small register files that must come
    // up holding the default filter, so unlike a RAM they are reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            shadow <= DEFAULT_BANK;
        else if (cfg_we && cfg_addr != 3'd7)
            shadow[cfg_addr] <= cfg_data;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_hist  <= '{default: '0};
            y_hist  <= '{default: '0};
            active  <= DEFAULT_BANK;
            acc     <= '0;
            tap     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_hist[0] <= x_in;
                        x_hist[1] <= x_hist[0];
                        x_hist[2] <= x_hist[1];
                        x_hist[3] <= x_hist[2];
                        // Coefficients are frozen for the whole sample.
                        active    <= shadow;
                        acc       <= '0;
                        tap       <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc + term;
                    tap <= tap + 3'd1;
                end
                ST_DONE: begin
                    y_out     <= sat(acc);
                    y_hist[0] <= sat(acc);
                    y_hist[1] <= y_hist[0];
                    y_hist[2] <= y_hist[1];
                    y_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- sticky overrun ----------------
    // A dropped sample outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ovr <= 1'b0;
        else if (start && state != ST_IDLE)
            ovr <= 1'b1;
        else if (clr_ovr)
            ovr <= 1'b0;
    end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iir_mac_sequencer
// Directed bench for iir_mac_sequencer. An arithmetic model computes the
// expected result and output cycle of each accepted sample; a compare
// process checks y_valid/y_out on every falling edge, and literal values
// pin the model at key points.
// ---------------------------------------------------------------------------
module tb_iir_mac_sequencer;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        lrck     = 1'b0;
    logic [19:0] x_in     = '0;
    logic        cfg_we   = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        clr_ovr  = 1'b0;
    logic [19:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        ovr;

    iir_mac_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .lrck     (lrck),
        .x_in     (x_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .clr_ovr  (clr_ovr),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .ovr      (ovr)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [19:0] y;
    } exp_t;

    exp_t        pend [$];
    int          shadow_m [7];
    logic [19:0] x_m [4];
    logic [19:0] y_m [3];
    logic [19:0] held_y;
    int          last_due;
    bit          ovr_m;

    function automatic int s8(input logic [7:0] v);
        logic signed [7:0] t;
        t = v;
        return int'(t);
    endfunction

    function automatic logic [19:0] sat_m(input int v);
        if (v > 524287)  return 20'h7FFFF;
        if (v < -524288) return 20'h80000;
        return 20'(v);
    endfunction

    task automatic model_reset();
        logic [7:0] defs [7];
        defs = '{8'h06, 8'h12, 8'h25, 8'h06, 8'h81, 8'h5B, 8'hEE};
        pend.delete();
        held_y   = '0;
        last_due = -100;
        ovr_m    = 1'b0;
        for (int i = 0; i < 7; i++) shadow_m[i] = s8(defs[i]);
        for (int i = 0; i < 4; i++) x_m[i] = '0;
        for (int i = 0; i < 3; i++) y_m[i] = '0;
    endtask

    // Raise lrck at a falling edge. The strobe is synchronized for two
    // clocks, so the start edge is the 3rd rising edge afterwards and the
    // result strobe follows the 11th.
    task automatic issue(input logic [19:0] x);
        int          r;
        int          acc_m;
        logic [19:0] y_new;
        @(negedge clock);
        lrck = 1'b1;
        x_in = x;
        r    = cyc;
        if (r + 3 > last_due) begin
            for (int i = 3; i > 0; i--) x_m[i] = x_m[i-1];
            x_m[0] = x;
            acc_m = 0;
            for (int i = 0; i < 4; i++) acc_m += s8(x_m[i][19:12]) * shadow_m[i] * 16;
            for (int i = 0; i < 3; i++) acc_m += s8(y_m[i][19:12]) * shadow_m[4+i] * 16;
            y_new = sat_m(acc_m);
            for (int i = 2; i > 0; i--) y_m[i] = y_m[i-1];
            y_m[0] = y_new;
            pend.push_back('{r + 11, y_new});
            last_due = r + 11;
        end else begin
            ovr_m = 1'b1;
        end
        @(negedge clock);
        lrck = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        if (a != 3'd7) shadow_m[a] = s8(d);
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("rst_y_out", 32'(y_out), 32'h0);
        check("rst_y_valid", 32'(y_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin : compare_proc
        logic exp_v;
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        check("y_valid", 32'(y_valid), 32'(exp_v));
        if (exp_v) begin
            held_y = pend[0].y;
            void'(pend.pop_front());
        end
        check("y_out", 32'(y_out), 32'(held_y));
    end

    // ---------------- directed stimulus ----------------
    initial begin
        model_reset();
        #22 reset = 1'b1;

        // Quiet after reset.
        wait_cyc(20);
        check("idle_y_out", 32'(y_out), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_ovr", 32'(ovr), 32'h0);

        // Impulse through the default filter.
        issue(20'h10000); wait_cyc(13);
        check("imp_1", 32'(y_out), 32'h00600);
        issue(20'h00000); wait_cyc(13);
        check("imp_2", 32'(y_out), 32'h01200);
        // x3*C2 = 16*37*16, y1 top byte 1 times C4 (-127) *16.
        issue(20'h00000); wait_cyc(13);
        check("imp_3", 32'(y_out), 32'h01D10);

        // Saturation with large feed-forward, no feedback.
        pulse_reset();
        for (int i = 0; i < 4; i++) cfg_write(3'(i), 8'h7F);
        for (int i = 4; i < 7; i++) cfg_write(3'(i), 8'h00);
        cfg_write(3'd7, 8'h55);
        issue(20'h7F000); wait_cyc(13);
        check("sat_1", 32'(y_out), 32'h3F010);
        issue(20'h7F000); wait_cyc(13);
        check("sat_2", 32'(y_out), 32'h7E020);
        issue(20'h7F000); wait_cyc(13);
        check("sat_3", 32'(y_out), 32'h7FFFF);

        // Overrun: second strobe three clocks later, clear in the same cycle.
        pulse_reset();
        issue(20'h10000);
        wait_cyc(1);
        issue(20'h10000);
        check("busy_mid", 32'(busy), 32'h1);
        wait_cyc(1);
        clr_ovr = 1'b1;
        wait_cyc(1);
        clr_ovr = 1'b0;
        wait_cyc(8);
        check("ovr_set", 32'(ovr), 32'(ovr_m));
        check("ovr_lit", 32'(ovr), 32'h1);
        check("ovr_y", 32'(y_out), 32'h00600);
        wait_cyc(1);
        clr_ovr = 1'b1;
        wait_cyc(1);
        clr_ovr = 1'b0;
        ovr_m   = 1'b0;
        check("ovr_clr", 32'(ovr), 32'h0);
        // x history advanced only once: x2 is the impulse, x1 is zero.
        issue(20'h00000); wait_cyc(13);
        check("ovr_hist", 32'(y_out), 32'h01200);

        // Shadow write during MAC affects only the next sample.
        pulse_reset();
        issue(20'h10000); wait_cyc(4);
        cfg_write(3'd0, 8'h00); wait_cyc(7);
        check("shadow_cur", 32'(y_out), 32'h00600);
        // Tap 0 now contributes nothing; only x2*C1 remains.
        issue(20'h10000); wait_cyc(13);
        check("shadow_next", 32'(y_out), 32'h01200);

        // Reset during tap 3 aborts the sample.
        pulse_reset();
        issue(20'h10000); wait_cyc(4);
        pulse_reset();
        wait_cyc(12);
        check("abort_y", 32'(y_out), 32'h0);
        issue(20'h10000); wait_cyc(13);
        check("abort_next", 32'(y_out), 32'h00600);

        wait_cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iir_mac_sequencer.md
IIR_MAC_SEQUENCER -- requirements
Module: iir_mac_sequencer

Interface
REQ-001 Parameters SHALL be:
  DATA_WIDTH, 20, sample/output width
  COEFF_WIDTH, 8, coefficient width
  ACC_WIDTH, 24, accumulator width
  C0..C6, 8'h06 8'h12 8'h25 8'h06 8'h81 8'h5B 8'hEE, coefficient reset values
REQ-002 Ports SHALL be:
  clock  in  1  single system clock, rising edge
  reset  in  1  asynchronous, active-low reset
  lrck  in  1  sample-rate strobe, asynchronous to clock
  x_in  in  DATA_WIDTH  signed input sample, stable around lrck rise
  cfg_we  in  1  coefficient write strobe
  cfg_addr  in  3  coefficient index 0..6; 7 ignored
  cfg_data  in  COEFF_WIDTH  signed coefficient value
  clr_ovr  in  1  clears ovr
  y_out  out  DATA_WIDTH  signed filtered sample
  y_valid  out  1  one-cycle pulse, new y_out
  busy  out  1  high when state != IDLE
  ovr  out  1  sticky overrun flag

Function
REQ-003 lrck SHALL pass a 2-flop synchronizer; start = rising edge of the synchronized signal (one extra flop for edge detect).
REQ-004 FSM states SHALL be IDLE, MAC, DONE; any unreachable encoding SHALL return to IDLE.
REQ-005 IDLE + start: shift x history (x1<=x_in, x2<=x1, x3<=x2, x4<=x3); copy shadow coeffs to active bank; acc<=0; tap<=0; go to MAC.
REQ-006 MAC: 7 cycles, tap 0..6, one multiply per cycle on a single shared multiplier; after tap 6, go to DONE.
REQ-007 Tap operands: taps 0..3 = x1..x4[19:12]; taps 4..6 = y1..y3[19:12]; coefficient = active[tap].
REQ-008 Per-tap term = sign-extended 16-bit product shifted left 4 (low 4 bits zero), added to the ACC_WIDTH signed acc.
REQ-009 DONE: y_out<=sat(acc); y history shifts (y1<=sat(acc), y2<=y1, y3<=y2); y_valid<=1; go to IDLE.
REQ-010 sat(): acc > 2^19-1 -> 20'h7FFFF; acc < -2^19 -> 20'h80000; otherwise acc[19:0].
REQ-011 Latency: y_valid SHALL be high for exactly the one cycle following the 8th clock edge after the start edge.
REQ-012 cfg_we with cfg_addr 0..6 SHALL write the shadow bank in any state. Active bank changes only at start, so a write during MAC affects the next sample only.
REQ-013 start while busy: sample SHALL be dropped (no history shift), ovr<=1, and the current computation continues unaffected.
REQ-014 clr_ovr SHALL clear ovr. If clr_ovr and an overrun occur in the same cycle, set wins.
REQ-015 y_out SHALL hold its value between y_valid pulses.

Reset
REQ-016 On reset low, immediately: state=IDLE, y_out=0, y_valid=0, busy=0, ovr=0, x1..x4=0, y1..y3=0, acc=0, tap=0, synchronizer flops=0, shadow and active banks = C0..C6.
REQ-017 Reset asserted mid-MAC SHALL abort the computation with no y_valid pulse. After release, the first start behaves as the first start after power-up.

Structure
REQ-018 A shared package SHALL hold DATA_WIDTH, COEFF_WIDTH, ACC_WIDTH, default coefficients C0..C6, and the FSM state type.
REQ-019 One sub-module, mult_tc, SHALL be instantiated once: 8x8 signed two's-complement multiply to a 16-bit product, combinational.

Verification
REQ-020 Reset: after reset release, with no lrck activity -> y_out=0, y_valid=0, busy=0, ovr=0 indefinitely.
REQ-021 Impulse with default coefficients: x_in=20'h10000, then x_in=0 for the following samples -> y_out=20'h00600 on the first sample, 20'h01200 on the second; exactly one y_valid per sample, 8 edges after start.
REQ-022 Saturation: write coeffs 0..3=8'h7F and 4..6=8'h00; drive x_in=20'h7F000 repeatedly -> y_out = 20'h3F010, then 20'h7E020, then 20'h7FFFF (clamped).
REQ-023 Overrun: second lrck rise arrives 3 clocks after the first -> ovr=1, only one y_valid pulse, x history advanced once. Pulse clr_ovr -> ovr=0.
REQ-024 Shadow coefficients: during MAC of the impulse sample, write cfg_addr=0, cfg_data=8'h00 -> current y_out=20'h00600; the next impulse sample gives y_out=20'h00000 from tap 0.
REQ-025 Reset mid-MAC: pull reset low at tap 3 -> no y_valid pulse, all outputs return to reset values. The next impulse after release gives y_out=20'h00600.
